// File: rtl/q_8_7_pkg.sv
// Shared types for the q_8_7 datapath: collector FSM encoding and result width.
package q_8_7_pkg;

    localparam int data_w        = 8;
    localparam int coll_st_width = 2;

    typedef enum logic [coll_st_width-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } coll_state_t;

endpackage

// File: rtl/q_8_7_result_fifo.sv
// First-word-fall-through result FIFO; head entry is presented combinationally.
module q_8_7_result_fifo
    import q_8_7_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [data_w-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [data_w-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [data_w-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_rd;

    // A read of an empty FIFO is ignored so the pointers can never cross.
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !do_rd) begin
                count <= count + CW'(1);
            end else if (!wr_en && do_rd) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/q_8_7_collector.sv
// Watches the subtractor start/rdy handshake, captures each result once into a
// FIFO, and flags dropped captures and hung operations.
module q_8_7_collector
    import q_8_7_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      rdy,
    input  logic [7:0]                result,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    output logic                      timeout_err,
    input  logic                      clr_err
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    coll_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          capture;
    logic          expire;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic          empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        capture   = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARMED;
                    timer_nxt = '0;
                end
            end
            // rdy idles high, so wait for it to fall before trusting a rising rdy.
            ARMED: begin
                if (timer == T_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (!rdy) begin
                        state_nxt = BUSY;
                    end
                    timer_nxt = (&timer) ? timer : timer + TW'(1);
                end
            end
            BUSY: begin
                if (rdy) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == T_LAST) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = (&timer) ? timer : timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A pop in the capture cycle frees the slot the capture needs.
    assign pop       = out_valid && out_ready;
    assign wr_en     = capture && (!full || pop);
    assign drop      = capture && full && !pop;
    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overflow    <= drop   || (overflow    && !clr_err);
            timeout_err <= expire || (timeout_err && !clr_err);
        end
    end

    q_8_7_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (result),
        .rd_en   (pop),
        .rd_data (out_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_q_8_7_collector.sv
// Directed and randomized checks of q_8_7_collector against a queue-based model.
module tb_q_8_7_collector;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic                   clk = 1'b0;
    logic                   rst, start, rdy, out_ready, clr_err;
    logic [7:0]             result, out_data;
    logic                   out_valid, full, overflow, timeout_err;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    // Model: results queue, handshake phase (0 idle, 1 waiting for rdy low,
    // 2 waiting for rdy high) and edges elapsed since the accepted start.
    byte unsigned mq[$];
    int           m_phase   = 0;
    int           m_elapsed = 0;
    bit           m_ovf     = 0;
    bit           m_tmo     = 0;

    q_8_7_collector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rdy         (rdy),
        .result      (result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, cap, expire;
        int n;
        if (rst) begin
            mq.delete();
            m_phase = 0; m_elapsed = 0; m_ovf = 0; m_tmo = 0;
            return;
        end
        pop = (mq.size() != 0) && out_ready;
        cap = 0; expire = 0;
        if (m_phase == 0) begin
            if (start) begin m_phase = 1; m_elapsed = 0; end
        end else begin
            m_elapsed++;
            if (m_phase == 2 && rdy) cap = 1;
            else if (m_elapsed >= TIMEOUT) expire = 1;
            else if (m_phase == 1 && !rdy) m_phase = 2;
            if (cap || expire) m_phase = 0;
        end
        n = mq.size();
        if (pop) void'(mq.pop_front());
        if (cap && (n < DEPTH || pop)) mq.push_back(result);
        m_ovf = (m_ovf && !clr_err) || (cap && n == DEPTH && !pop);
        m_tmo = (m_tmo && !clr_err) || expire;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("count", count, mq.size());
        check("valid", out_valid, mq.size() != 0);
        check("full", full, mq.size() == DEPTH);
        check("ovf", overflow, m_ovf);
        check("tmo", timeout_err, m_tmo);
        if (mq.size() != 0) check("data", out_data, mq[0]);
    endtask

    task automatic op(input logic [7:0] res, input bit pop_at_cap);
        start = 1; rdy = 1; cyc();
        start = 0; rdy = 0; repeat (3) cyc();
        rdy = 1; result = res; out_ready = pop_at_cap; cyc();
        out_ready = 0;
    endtask

    task automatic pop_one(input string tag, input logic [7:0] exp);
        check(tag, out_data, exp);
        out_ready = 1; cyc(); out_ready = 0;
    endtask

    initial begin
        int first;
        int c0;
        rst = 1; start = 0; rdy = 1; out_ready = 0; clr_err = 0; result = 0;
        repeat (2) cyc();
        rst = 0; cyc();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_flags", {overflow, timeout_err, full}, 0);

        // single op
        op(8'd17, 0);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 17);
        check("single_count", count, 1);
        out_ready = 1; cyc(); out_ready = 0;
        check("single_pop", count, 0);

        // order and fill
        op(8'd30, 0); op(8'd226, 0); op(8'd0, 0); op(8'd226, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 4);
        pop_one("ord0", 30); pop_one("ord1", 226); pop_one("ord2", 0); pop_one("ord3", 226);
        check("drain_valid", out_valid, 0);

        // overflow, then capture with simultaneous pop
        op(8'd30, 0); op(8'd226, 0); op(8'd0, 0); op(8'd226, 0);
        op(8'd5, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 4);
        check("ovf_head", out_data, 30);
        op(8'd5, 1);
        check("cappop_count", count, 4);
        pop_one("cp0", 226); pop_one("cp1", 0); pop_one("cp2", 226); pop_one("cp3", 5);

        // timeout
        clr_err = 1; cyc(); clr_err = 0;
        op(8'd77, 0);
        c0 = count;
        start = 1; rdy = 1; cyc(); start = 0; rdy = 0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (timeout_err && first < 0) first = k;
        end
        check("to_latency", first, 32);
        check("to_count", count, c0);
        op(8'd99, 0);
        check("to_idle_capture", count, c0 + 1);
        clr_err = 1; cyc(); clr_err = 0;
        check("clr_flags", {overflow, timeout_err}, 0);

        // reset mid-operation
        start = 1; rdy = 1; cyc(); start = 0; rdy = 0; repeat (2) cyc();
        rst = 1; cyc(); rst = 0;
        check("midrst_count", count, 0);
        rdy = 1; result = 8'd44; repeat (3) cyc();
        check("midrst_nocap", out_valid, 0);

        // idle rdy high
        repeat (20) cyc();
        check("idle_rdy", count, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            rdy       = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 5 : 1));
            result    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
